// File: rtl/mux_counter_pkg.sv
// Shared types and defaults for the multiplexed-counter divider control slice.
package mux_counter_pkg;

  localparam int unsigned DIV_W = 32;
  localparam logic [7:0] SYNC_CODE_DEF = 8'h7B;
  localparam logic [DIV_W-1:0] DEFAULT_DIV_DEF = 32'd2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RESYNC
  } ctrl_state_t;

endpackage

// File: rtl/mux_counter_chan.sv
// One divider channel: shadow ratio written by software, active ratio driven
// to the divider, and a dirty flag marking a pending shadow->active commit.
module mux_counter_chan
  import mux_counter_pkg::*;
#(
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_data,
  input  logic             load,
  output logic [DIV_W-1:0] active,
  output logic             dirty
);

  logic [DIV_W-1:0] shadow;

  // A write in the load cycle commits the old shadow and leaves dirty set
  // so the new value goes out with the next commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= DEFAULT_DIV;
      active <= DEFAULT_DIV;
      dirty  <= 1'b0;
    end else begin
      if (load && dirty) begin
        active <= shadow;
      end
      if (wr_en) begin
        shadow <= wr_data;
        dirty  <= 1'b1;
      end else if (load) begin
        dirty  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_counter_ctrl.sv
// Control stage for the divider bank: shadow/active ratios per channel,
// commit on sync event or software strobe, then a fixed reset window.
module mux_counter_ctrl
  import mux_counter_pkg::*;
#(
  parameter int unsigned      N_CH        = 8,
  parameter int unsigned      ADDR_W      = 4,
  parameter logic [7:0]       SYNC_CODE   = SYNC_CODE_DEF,
  parameter int unsigned      RST_CYCLES  = 4,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DIV_W-1:0]      wr_data,
  output logic                  wr_ack,
  output logic                  wr_err,
  input  logic                  commit,
  input  logic                  ev_valid,
  input  logic [7:0]            ev_code,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DIV_W-1:0]      rd_data,
  output logic [N_CH*DIV_W-1:0] divide_data,
  output logic [N_CH-1:0]       div_rst,
  output logic                  busy
);

  localparam int unsigned CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W:0] N_CH_L = (ADDR_W + 1)'(N_CH);

  ctrl_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_CH-1:0]  div_rst_n;
  logic [N_CH-1:0]  dirty;
  logic             load;
  logic             trigger;
  logic             addr_ok;
  logic [DIV_W-1:0] active [N_CH];
  logic [DIV_W-1:0] rd_mux;

  assign trigger = commit | (ev_valid & (ev_code == SYNC_CODE));
  assign addr_ok = ({1'b0, wr_addr} < N_CH_L);

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    logic chan_wr;
    assign chan_wr = wr_en & addr_ok & (wr_addr == ADDR_W'(k));

    mux_counter_chan #(
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (chan_wr),
      .wr_data (wr_data),
      .load    (load),
      .active  (active[k]),
      .dirty   (dirty[k])
    );

    assign divide_data[k*DIV_W +: DIV_W] = active[k];
  end

  // Reset lands in RESYNC with every channel masked, so all dividers
  // restart on DEFAULT_DIV through the same window as a normal commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RESYNC;
      cnt     <= CNT_INIT;
      div_rst <= '1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div_rst <= div_rst_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    div_rst_n = div_rst;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (trigger && (|dirty)) begin
          state_n = LOAD;
        end
      end
      LOAD: begin
        load      = 1'b1;
        state_n   = RESYNC;
        cnt_n     = CNT_INIT;
        div_rst_n = dirty;
      end
      RESYNC: begin
        if (cnt == '0) begin
          state_n   = IDLE;
          div_rst_n = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_mux = active[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack  <= 1'b0;
      wr_err  <= 1'b0;
      rd_data <= '0;
    end else begin
      wr_ack  <= wr_en;
      wr_err  <= wr_en & ~addr_ok;
      rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_mux_counter_ctrl.sv
// Bench for mux_counter_ctrl: directed vector table, hand sequences for the
// load-cycle write / dropped trigger / mid-window reset, and random traffic.
module tb_mux_counter_ctrl;

  localparam int NCH = 8;
  localparam int RSTC = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wr_en;
  logic [3:0]     wr_addr;
  logic [31:0]    wr_data;
  logic           wr_ack;
  logic           wr_err;
  logic           commit;
  logic           ev_valid;
  logic [7:0]     ev_code;
  logic [3:0]     rd_addr;
  logic [31:0]    rd_data;
  logic [NCH*32-1:0] divide_data;
  logic [NCH-1:0] div_rst;
  logic           busy;

  always #5 clk = ~clk;

  mux_counter_ctrl #(
    .N_CH        (NCH),
    .ADDR_W      (4),
    .SYNC_CODE   (8'h7B),
    .RST_CYCLES  (RSTC),
    .DEFAULT_DIV (32'd2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .wr_err      (wr_err),
    .commit      (commit),
    .ev_valid    (ev_valid),
    .ev_code     (ev_code),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .divide_data (divide_data),
    .div_rst     (div_rst),
    .busy        (busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Timeline model: a commit is remembered by the cycle index of its load
  // cycle; busy and the reset window are ranges relative to that index.
  logic [31:0] m_sh  [NCH];
  logic [31:0] m_act [NCH];
  bit          m_dirty [NCH];
  logic [7:0]  m_mask;
  int          load_cyc;
  int          cyc;
  logic [31:0] m_rd;
  bit          m_ack, m_err;

  function automatic bit m_busy(int c);
    return (c >= load_cyc) && (c <= load_cyc + RSTC);
  endfunction

  function automatic logic [7:0] m_rst(int c);
    return ((c >= load_cyc + 1) && (c <= load_cyc + RSTC)) ? m_mask : 8'h00;
  endfunction

  function automatic logic [31:0] ratio(int k);
    return divide_data[32*k +: 32];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic model_init();
    for (int k = 0; k < NCH; k++) begin
      m_sh[k] = 32'd2;
      m_act[k] = 32'd2;
      m_dirty[k] = 1'b0;
    end
    m_mask = 8'hFF;
    load_cyc = -1;
    cyc = 0;
    m_rd = '0;
    m_ack = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_update();
    bit trig, any;
    int new_load;
    int ra;
    ra = int'(rd_addr);
    m_rd = (ra < NCH) ? m_act[ra] : 32'd0;
    m_ack = wr_en;
    m_err = wr_en && (int'(wr_addr) >= NCH);
    trig = commit || (ev_valid && ev_code == 8'h7B);
    any = 1'b0;
    for (int k = 0; k < NCH; k++) any |= m_dirty[k];
    new_load = load_cyc;
    if (trig && !m_busy(cyc) && any) new_load = cyc + 1;
    if (cyc == load_cyc) begin
      for (int k = 0; k < NCH; k++) begin
        m_mask[k] = m_dirty[k];
        if (m_dirty[k]) begin
          m_act[k] = m_sh[k];
          m_dirty[k] = 1'b0;
        end
      end
    end
    if (wr_en && int'(wr_addr) < NCH) begin
      m_sh[int'(wr_addr)] = wr_data;
      m_dirty[int'(wr_addr)] = 1'b1;
    end
    load_cyc = new_load;
    cyc++;
  endtask

  task automatic compare_model();
    chk("div_rst", 32'(div_rst), 32'(m_rst(cyc)));
    chk("busy", 32'(busy), 32'(m_busy(cyc)));
    chk("wr_ack", 32'(wr_ack), 32'(m_ack));
    chk("wr_err", 32'(wr_err), 32'(m_err));
    chk("rd_data", rd_data, m_rd);
    for (int k = 0; k < NCH; k++) chk($sformatf("ratio%0d", k), ratio(k), m_act[k]);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_model();
  endtask

  task automatic set_in(bit we, int wa, logic [31:0] wd, bit cm, bit ev, logic [7:0] ec);
    wr_en = we;
    wr_addr = 4'(wa);
    wr_data = wd;
    commit = cm;
    ev_valid = ev;
    ev_code = ec;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    rd_addr = '0;
    @(posedge clk);
    #1;
    chk("rst_div_rst", 32'(div_rst), 32'hFF);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    for (int k = 0; k < NCH; k++) chk($sformatf("rst_ratio%0d", k), ratio(k), 32'd2);
    rst_n = 1'b1;
    model_init();
  endtask

  typedef struct {
    bit          we;
    int          wa;
    logic [31:0] wd;
    bit          cm;
    bit          ev;
    logic [7:0]  ec;
    logic [7:0]  e_rst;
    bit          e_busy;
    bit          e_ack;
    bit          e_err;
    int          pch;
    logic [31:0] pval;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit we, int wa, logic [31:0] wd, bit cm, bit ev, logic [7:0] ec,
                              logic [7:0] er, bit eb, bit ea, bit ee, int pch, logic [31:0] pv);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.cm = cm; v.ev = ev; v.ec = ec;
    v.e_rst = er; v.e_busy = eb; v.e_ack = ea; v.e_err = ee; v.pch = pch; v.pval = pv;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Row i: inputs for one cycle; expectations seen in the following cycle.
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'hFF, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'hFF, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'hFF, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'h00, 0, 0, 0, 7, 2));
    tbl.push_back(mk(1, 3, 10, 0, 0, 8'h00, 8'h00, 0, 1, 0, 3, 2));
    tbl.push_back(mk(0, 0, 0,  1, 0, 8'h00, 8'h00, 1, 0, 0, 3, 2));
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'h08, 1, 0, 0, 3, 10));
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'h08, 1, 0, 0, 3, 10));
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'h08, 1, 0, 0, 3, 10));
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'h08, 1, 0, 0, 3, 10));
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'h00, 0, 0, 0, 2, 2));
    tbl.push_back(mk(1, 1, 6,  0, 0, 8'h00, 8'h00, 0, 1, 0, 1, 2));
    tbl.push_back(mk(1, 5, 0,  0, 0, 8'h00, 8'h00, 0, 1, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0,  0, 1, 8'h7A, 8'h00, 0, 0, 0, 5, 2));
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'h00, 0, 0, 0, 5, 2));
    tbl.push_back(mk(0, 0, 0,  0, 1, 8'h7B, 8'h00, 1, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'h22, 1, 0, 0, 1, 6));
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'h22, 1, 0, 0, 5, 0));
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'h22, 1, 0, 0, 1, 6));
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'h22, 1, 0, 0, 1, 6));
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'h00, 0, 0, 0, 5, 0));
    tbl.push_back(mk(0, 0, 0,  1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'h00, 0, 0, 0, 3, 10));
    tbl.push_back(mk(0, 0, 0,  0, 0, 8'h00, 8'h00, 0, 0, 0, 3, 10));
    tbl.push_back(mk(1, 9, 99, 0, 0, 8'h00, 8'h00, 0, 1, 1, 1, 6));
    tbl.push_back(mk(0, 0, 0,  1, 0, 8'h00, 8'h00, 0, 0, 0, 1, 6));

    do_reset();
    compare_model();

    foreach (tbl[i]) begin
      set_in(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].cm, tbl[i].ev, tbl[i].ec);
      rd_addr = 4'(tbl[i].pch);
      step();
      chk($sformatf("tbl%0d_div_rst", i), 32'(div_rst), 32'(tbl[i].e_rst));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_wr_ack", i), 32'(wr_ack), 32'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_wr_err", i), 32'(wr_err), 32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_ratio%0d", i, tbl[i].pch), ratio(tbl[i].pch), tbl[i].pval);
    end

    // Write landing in the LOAD cycle, then a trigger dropped during RESYNC.
    set_in(1, 2, 8, 0, 0, 0);  step();
    set_in(0, 0, 0, 1, 0, 0);  step();
    chk("ld_busy", 32'(busy), 32'd1);
    set_in(1, 2, 20, 0, 0, 0); step();
    chk("ld_ch2_old", ratio(2), 32'd8);
    chk("ld_div_rst", 32'(div_rst), 32'h04);
    set_in(0, 0, 0, 1, 0, 0);  step();
    set_in(0, 0, 0, 0, 0, 0);  step(); step(); step();
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_div_rst", 32'(div_rst), 32'h00);
    chk("drop_ch2", ratio(2), 32'd8);
    set_in(0, 0, 0, 1, 0, 0);  step();
    set_in(0, 0, 0, 0, 0, 0);  step();
    chk("second_ch2", ratio(2), 32'd20);
    chk("second_div_rst", 32'(div_rst), 32'h04);
    repeat (5) step();

    // Reset asserted in the middle of a reset window.
    set_in(1, 6, 3, 0, 0, 0);  step();
    set_in(0, 0, 0, 1, 0, 0);  step();
    set_in(0, 0, 0, 0, 0, 0);  step(); step();
    chk("pre_rst_ch6", ratio(6), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("async_div_rst", 32'(div_rst), 32'hFF);
    chk("async_busy", 32'(busy), 32'd1);
    chk("async_ch6", ratio(6), 32'd2);
    chk("async_ch2", ratio(2), 32'd2);
    do_reset();
    repeat (6) step();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        wr_en    = ($urandom_range(0, 9) < 3);
        wr_addr  = 4'($urandom_range(0, 15));
        wr_data  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1)) : $urandom;
        commit   = ($urandom_range(0, 19) == 0);
        ev_valid = ($urandom_range(0, 9) == 0);
        ev_code  = ($urandom_range(0, 1) == 1) ? 8'h7B : 8'($urandom);
        rd_addr  = 4'($urandom_range(0, 15));
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
